sim_run_controller: RTL and testbench

Synthesizable run controller and result checker for the Processor_Top bench. It takes over what is currently hand-coded in the testbench: reset sequencing, run timeout and end-of-test detection. End of test is either an ebreak or a jal-to-self loop. On halt it walks the register file through a read port, streams each register out, and folds the contents into a rotate-XOR signature checked against an expected value.

---
 rtl/sim_run_if.sv | 50 +++++
 rtl/sim_run_controller.sv | 189 ++++++++++++++++++
 tb/tb_sim_run_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sim_run_if.sv
// Bundle between the run controller and the processor bench: core control,
// commit trace, register-file debug read port, dump stream and result status.
interface sim_run_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
);
  localparam int AW = $clog2(NUM_REGS);

  // Core control
  logic            core_rst;
  logic            core_stall;

  // Commit trace from the core
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_instr;

  // Register-file debug read port
  logic [AW-1:0]   rf_rd_addr;
  logic [XLEN-1:0] rf_rd_data;

  // Golden signature
  logic [XLEN-1:0] expected_sig;

  // Dump stream and status
  logic            dump_valid;
  logic [AW-1:0]   dump_idx;
  logic [XLEN-1:0] dump_data;
  logic [XLEN-1:0] signature;
  logic [31:0]     cycle_count;
  logic [31:0]     retired_count;
  logic [1:0]      halt_cause;
  logic            timeout;
  logic            done;
  logic            pass;

  // Controller side
  modport master (
    input  commit_valid, commit_pc, commit_instr, rf_rd_data, expected_sig,
    output core_rst, core_stall, rf_rd_addr, dump_valid, dump_idx, dump_data,
           signature, cycle_count, retired_count, halt_cause, timeout, done, pass
  );

  // Bench / core side
  modport slave (
    output commit_valid, commit_pc, commit_instr, rf_rd_data, expected_sig,
    input  core_rst, core_stall, rf_rd_addr, dump_valid, dump_idx, dump_data,
           signature, cycle_count, retired_count, halt_cause, timeout, done, pass
  );
endinterface

// File: rtl/sim_run_controller.sv
// Run controller for the processor bench: sequences the core reset, watches
// the commit stream for end of test (ebreak, jal-to-self loop or timeout),
// then scans the register file and folds it into a rotate-XOR signature.
module sim_run_controller #(
  parameter int          XLEN         = 32,
  parameter int          NUM_REGS     = 32,
  parameter int          RESET_CYCLES = 4,
  parameter int          MAX_CYCLES   = 1500,
  parameter int          LOOP_THRESH  = 8,
  parameter logic [31:0] HALT_INSTR   = 32'h00100073
) (
  input  logic    clk,
  input  logic    rst,
  sim_run_if.master bus
);

  localparam int AW  = $clog2(NUM_REGS);
  localparam int DCW = $clog2(NUM_REGS + 1);
  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam int LCW = $clog2(LOOP_THRESH + 1);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_EBREAK  = 2'b01;
  localparam logic [1:0] CAUSE_LOOP    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_RESET_HOLD,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_e;

  state_e          state_q,      state_d;
  logic [RCW-1:0]  rst_cnt_q,    rst_cnt_d;
  logic [31:0]     cycle_q,      cycle_d;
  logic [31:0]     retired_q,    retired_d;
  logic [XLEN-1:0] last_pc_q,    last_pc_d;
  logic [LCW-1:0]  loop_cnt_q,   loop_cnt_d;
  logic [1:0]      cause_q,      cause_d;
  logic            timeout_q,    timeout_d;
  logic [DCW-1:0]  dump_cnt_q,   dump_cnt_d;
  logic            dump_valid_q, dump_valid_d;
  logic [AW-1:0]   dump_idx_q,   dump_idx_d;
  logic [XLEN-1:0] sig_q,        sig_d;
  logic            done_q,       done_d;
  logic            pass_q,       pass_d;

  logic [LCW-1:0]  loop_next;
  logic            hit_instr;
  logic            hit_loop;
  logic            hit_timeout;

  // Next-state and datapath decisions for the whole run sequence
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    cycle_d      = cycle_q;
    retired_d    = retired_q;
    last_pc_d    = last_pc_q;
    loop_cnt_d   = loop_cnt_q;
    cause_d      = cause_q;
    timeout_d    = timeout_q;
    dump_cnt_d   = dump_cnt_q;
    dump_valid_d = 1'b0;
    dump_idx_d   = dump_idx_q;
    sig_d        = sig_q;
    done_d       = done_q;
    pass_d       = pass_q;
    loop_next    = LCW'(1);
    hit_instr    = 1'b0;
    hit_loop     = 1'b0;
    hit_timeout  = 1'b0;

    unique case (state_q)
      S_RESET_HOLD: begin
        if (rst_cnt_q == RCW'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end

      S_RUN: begin
        if (cycle_q != '1) cycle_d = cycle_q + 32'd1;
        hit_timeout = (cycle_q == 32'(MAX_CYCLES - 1));

        if (bus.commit_valid) begin
          if (retired_q != '1) retired_d = retired_q + 32'd1;
          // loop_cnt_q==0 means no commit seen since reset
          if ((loop_cnt_q != '0) && (bus.commit_pc == last_pc_q)) begin
            loop_next = loop_cnt_q + LCW'(1);
          end
          loop_cnt_d = loop_next;
          last_pc_d  = bus.commit_pc;
          hit_instr  = (bus.commit_instr == HALT_INSTR);
          hit_loop   = (loop_next == LCW'(LOOP_THRESH));
        end

        if (hit_instr) begin
          cause_d = CAUSE_EBREAK;
        end else if (hit_loop) begin
          cause_d = CAUSE_LOOP;
        end else if (hit_timeout) begin
          cause_d   = CAUSE_TIMEOUT;
          timeout_d = 1'b1;
        end

        if (hit_instr || hit_loop || hit_timeout) state_d = S_DUMP;
      end

      S_DUMP: begin
        // Read data for the address issued last cycle arrives now
        if (dump_valid_q) begin
          sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ bus.rf_rd_data;
        end
        if (dump_cnt_q < DCW'(NUM_REGS)) begin
          dump_valid_d = 1'b1;
          dump_idx_d   = dump_cnt_q[AW-1:0];
          dump_cnt_d   = dump_cnt_q + DCW'(1);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (sig_d == bus.expected_sig) && (cause_q != CAUSE_TIMEOUT);
        end
      end

      S_DONE: begin
        // Result is held until the next reset
      end

      default: state_d = S_RESET_HOLD;
    endcase
  end

  // State and status registers, cleared asynchronously on rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RESET_HOLD;
      rst_cnt_q    <= '0;
      cycle_q      <= '0;
      retired_q    <= '0;
      last_pc_q    <= '0;
      loop_cnt_q   <= '0;
      cause_q      <= CAUSE_NONE;
      timeout_q    <= 1'b0;
      dump_cnt_q   <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      sig_q        <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the values from
      // before this edge regardless of statement order.
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cycle_q      <= cycle_d;
      retired_q    <= retired_d;
      last_pc_q    <= last_pc_d;
      loop_cnt_q   <= loop_cnt_d;
      cause_q      <= cause_d;
      timeout_q    <= timeout_d;
      dump_cnt_q   <= dump_cnt_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      sig_q        <= sig_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign bus.core_rst      = (state_q != S_RESET_HOLD);
  assign bus.core_stall    = (state_q == S_DUMP) || (state_q == S_DONE);
  assign bus.rf_rd_addr    = dump_cnt_q[AW-1:0];
  assign bus.dump_valid    = dump_valid_q;
  assign bus.dump_idx      = dump_idx_q;
  assign bus.dump_data     = dump_valid_q ? bus.rf_rd_data : '0;
  assign bus.signature     = sig_q;
  assign bus.cycle_count   = cycle_q;
  assign bus.retired_count = retired_q;
  assign bus.halt_cause    = cause_q;
  assign bus.timeout       = timeout_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: reset sequencing, ebreak, self-loop
// and timeout halts, signature pass/fail and reset in the middle of a dump.
module tb_sim_run_controller;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_sig;

  sim_run_if #(.XLEN(32), .NUM_REGS(32)) bus ();

  sim_run_controller #(
    .XLEN(32), .NUM_REGS(32), .RESET_CYCLES(4), .MAX_CYCLES(1500),
    .LOOP_THRESH(8), .HALT_INSTR(32'h00100073)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: R[i] = i, synchronous read
  always @(posedge clk) bus.rf_rd_data <= {27'd0, bus.rf_rd_addr};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_sig();
    logic [31:0] s = '0;
    for (int i = 0; i < 32; i++) s = {s[30:0], s[31]} ^ 32'(i);
    return s;
  endfunction

  task automatic drive_commit(input logic [31:0] pc, input logic [31:0] instr);
    @(negedge clk);
    bus.commit_valid = 1'b1;
    bus.commit_pc    = pc;
    bus.commit_instr = instr;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_core_rst"},   bus.core_rst, 0);
    check({tag, "_core_stall"}, bus.core_stall, 0);
    check({tag, "_dump_valid"}, bus.dump_valid, 0);
    check({tag, "_rf_addr"},    bus.rf_rd_addr, 0);
    check({tag, "_sig"},        bus.signature, 0);
    check({tag, "_cycles"},     bus.cycle_count, 0);
    check({tag, "_retired"},    bus.retired_count, 0);
    check({tag, "_cause"},      bus.halt_cause, 0);
    check({tag, "_timeout"},    bus.timeout, 0);
    check({tag, "_done"},       bus.done, 0);
    check({tag, "_pass"},       bus.pass, 0);
  endtask

  // rst low 3 cycles, release, core_rst must stay low exactly 4 edges
  task automatic do_reset();
    bus.commit_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_core_rst_3", bus.core_rst, 0);
    @(negedge clk);
    check("hold_core_rst_4", bus.core_rst, 1);
    check("run_cycles_start", bus.cycle_count, 0);
    check("run_stall", bus.core_stall, 0);
  endtask

  // Called at the negedge of the first DUMP cycle
  task automatic dump_and_finish(input logic exp_pass);
    check("dump0_valid", bus.dump_valid, 0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("dump_valid", bus.dump_valid, 1);
      check("dump_idx",   bus.dump_idx, 64'(i));
      check("dump_data",  bus.dump_data, 64'(i));
      check("dump_done",  bus.done, 0);
    end
    @(negedge clk);
    check("done",          bus.done, 1);
    check("done_dv",       bus.dump_valid, 0);
    check("done_stall",    bus.core_stall, 1);
    check("done_sig",      bus.signature, exp_sig);
    check("done_pass",     bus.pass, exp_pass);
    repeat (3) @(negedge clk);
    check("done_sticky",   bus.done, 1);
    check("pass_sticky",   bus.pass, exp_pass);
  endtask

  task automatic ebreak_run();
    drive_commit(32'h0, NOP);
    drive_commit(32'h4, NOP);
    drive_commit(32'h8, NOP);
    drive_commit(32'hC, EBREAK);
    check("eb_stall_before", bus.core_stall, 0);
    @(negedge clk);
    bus.commit_valid = 1'b0;
    check("eb_stall",   bus.core_stall, 1);
    check("eb_cause",   bus.halt_cause, 2'b01);
    check("eb_retired", bus.retired_count, 4);
    check("eb_cycles",  bus.cycle_count, 5);
    check("eb_timeout", bus.timeout, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.commit_valid = 1'b0;
    bus.commit_pc    = '0;
    bus.commit_instr = '0;
    bus.expected_sig = '0;
    exp_sig = model_sig();

    // ebreak halt with matching signature
    do_reset();
    bus.expected_sig = exp_sig;
    ebreak_run();
    dump_and_finish(1'b1);
    check("eb_cycles_frozen", bus.cycle_count, 5);

    // Self-loop halt on 8th commit at same PC, wrong signature
    do_reset();
    bus.expected_sig = exp_sig ^ 32'h1;
    repeat (7) drive_commit(32'h20, NOP);
    @(negedge clk);
    bus.commit_valid = 1'b1;
    check("loop7_stall", bus.core_stall, 0);
    @(negedge clk);
    bus.commit_valid = 1'b0;
    check("loop_stall",   bus.core_stall, 1);
    check("loop_cause",   bus.halt_cause, 2'b10);
    check("loop_retired", bus.retired_count, 8);
    dump_and_finish(1'b0);

    // 7 at 0x20 then 0x24: loop count restarts, halts on 8th 0x24
    do_reset();
    bus.expected_sig = exp_sig;
    repeat (7) drive_commit(32'h20, NOP);
    repeat (7) drive_commit(32'h24, NOP);
    drive_commit(32'h24, NOP);
    check("restart_no_halt", bus.core_stall, 0);
    @(negedge clk);
    bus.commit_valid = 1'b0;
    check("restart_stall",   bus.core_stall, 1);
    check("restart_cause",   bus.halt_cause, 2'b10);
    check("restart_retired", bus.retired_count, 15);
    dump_and_finish(1'b1);

    // Timeout with matching signature still fails
    do_reset();
    bus.expected_sig = exp_sig;
    repeat (1499) @(negedge clk);
    check("to_stall_1499",  bus.core_stall, 0);
    check("to_cycles_1499", bus.cycle_count, 1499);
    @(negedge clk);
    check("to_stall",   bus.core_stall, 1);
    check("to_cause",   bus.halt_cause, 2'b11);
    check("to_flag",    bus.timeout, 1);
    check("to_cycles",  bus.cycle_count, 1500);
    check("to_retired", bus.retired_count, 0);
    dump_and_finish(1'b0);
    check("to_cycles_frozen", bus.cycle_count, 1500);

    // Reset in the middle of the dump, then an identical re-run
    do_reset();
    bus.expected_sig = exp_sig;
    ebreak_run();
    repeat (11) @(negedge clk);
    check("mid_idx", bus.dump_idx, 10);
    #2 rst = 1'b0;
    #1 check_idle_outputs("mid_async");
    do_reset();
    ebreak_run();
    dump_and_finish(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
